leitor_framebuffer: RTL and testbench

- Read-side counterpart of the frame copier: streams a stored 160x120, 8-bit frame out of the framebuffer RAM, in raster order, to a downstream consumer.
- On a start pulse it issues sequential RAM reads, absorbs the RAM's one-cycle read latency in a 2-entry buffer, and presents pixels on a valid/ready stream with start-of-frame and end-of-line markers.
- Sits between the framebuffer RAM read port and the display/processing pipeline.

---
 rtl/leitor_framebuffer.sv | 215 +++++++++++++++++++++
 tb/tb_leitor_framebuffer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/leitor_framebuffer.sv
// leitor_framebuffer: streams a stored IMG_W x IMG_H, 8-bit frame out of the
// framebuffer RAM in raster order onto a valid/ready pixel stream with
// start-of-frame and end-of-line markers.
//
// RAM reads are issued one per cycle while credits allow. A 2-entry FIFO
// absorbs the one-cycle RAM read latency. Credits count FIFO entries plus the
// in-flight read, so the FIFO cannot overflow under backpressure.
//
// Optional build macro: LEITOR_FRAMEBUFFER_LOOP_EN
//   defined   -> continuous scan-out; the read counter wraps after the last
//                pixel, busy stays high and done never sets.
//   undefined -> one frame per start pulse.
module leitor_framebuffer #(
    parameter int IMG_W     = 160,
    parameter int IMG_H     = 120,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_rdaddr,
    output logic              ram_rden,
    input  logic [7:0]        ram_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              busy,
    output logic              done
);

    localparam int N     = IMG_W * IMG_H;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    // FIFO entry layout: {data[7:0], sof, eol}
    localparam int ENT_W = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               ram_rden_q, ram_rden_d;
    logic [ADDR_W-1:0]  ram_rdaddr_q, ram_rdaddr_d;
    logic               tag_sof_q, tag_sof_d;
    logic               tag_eol_q, tag_eol_d;
    logic [ENT_W-1:0]   fifo0_q, fifo0_d;
    logic [ENT_W-1:0]   fifo1_q, fifo1_d;
    logic [1:0]         count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               push;
    logic               pop;
    logic               issue;
    logic               last_cnt;
    logic               col_last;
    logic [2:0]         credit_use;
    logic [ENT_W-1:0]   entry_in;

    // Handshake, credit and issue decisions for the current cycle
    always_comb begin
        push       = ram_rden_q;
        pop        = (count_q != 2'd0) && pix_ready;
        // Occupancy after this edge's pop plus the read still in flight;
        // counting the pop lets a full-rate stream keep issuing every cycle.
        credit_use = {1'b0, count_q} + {2'b00, ram_rden_q} - {2'b00, pop};
        issue      = (state_q == S_READ) && (credit_use < 3'd2);
        last_cnt   = (rd_cnt_q == CNT_W'(N - 1));
        col_last   = (col_q == COL_W'(IMG_W - 1));
        entry_in   = {ram_data, tag_sof_q, tag_eol_q};
    end

    // Next-state logic: FSM, read counter, address and marker tagging
    always_comb begin
        state_d      = state_q;
        rd_cnt_d     = rd_cnt_q;
        col_d        = col_q;
        ram_rden_d   = issue;
        ram_rdaddr_d = ram_rdaddr_q;
        tag_sof_d    = tag_sof_q;
        tag_eol_d    = tag_eol_q;
        busy_d       = busy_q;
        done_d       = done_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    busy_d   = 1'b1;
                    rd_cnt_d = '0;
                    col_d    = '0;
                    state_d  = S_READ;
                end
            end

            S_READ: begin
                if (issue) begin
                    ram_rdaddr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_cnt_q);
                    // Markers travel with the read so the FIFO head carries
                    // them without any division on the output side.
                    tag_sof_d    = (rd_cnt_q == '0);
                    tag_eol_d    = col_last;
                    col_d        = col_last ? '0 : col_q + COL_W'(1);
                    if (last_cnt) begin
`ifdef LEITOR_FRAMEBUFFER_LOOP_EN
                        rd_cnt_d = '0;
`else
                        state_d  = S_DRAIN;
`endif
                    end else begin
                        rd_cnt_d = rd_cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                // No reads remain; the frame ends when the only pixel left
                // (the last one) is handed off.
                if (pop && (count_q == 2'd1) && !ram_rden_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Two-entry FIFO: fifo0 is always the head, fifo1 the second entry
    always_comb begin
        fifo0_d = fifo0_q;
        fifo1_d = fifo1_q;
        count_d = count_q;

        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    fifo0_d = entry_in;
                end else begin
                    fifo1_d = entry_in;
                end
                count_d = count_q + 2'd1;
            end

            2'b01: begin
                fifo0_d = fifo1_q;
                count_d = count_q - 2'd1;
            end

            2'b11: begin
                if (count_q == 2'd1) begin
                    fifo0_d = entry_in;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = entry_in;
                end
            end

            default: begin
            end
        endcase
    end

    // State registers; async reset also discards any in-flight read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rd_cnt_q     <= '0;
            col_q        <= '0;
            ram_rden_q   <= 1'b0;
            ram_rdaddr_q <= ADDR_W'(BASE_ADDR);
            tag_sof_q    <= 1'b0;
            tag_eol_q    <= 1'b0;
            fifo0_q      <= '0;
            fifo1_q      <= '0;
            count_q      <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_cnt_q     <= rd_cnt_d;
            col_q        <= col_d;
            ram_rden_q   <= ram_rden_d;
            ram_rdaddr_q <= ram_rdaddr_d;
            tag_sof_q    <= tag_sof_d;
            tag_eol_q    <= tag_eol_d;
            fifo0_q      <= fifo0_d;
            fifo1_q      <= fifo1_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign ram_rdaddr = ram_rdaddr_q;
    assign ram_rden   = ram_rden_q;
    assign pix_valid  = (count_q != 2'd0);
    assign pix_data   = fifo0_q[9:2];
    assign pix_sof    = fifo0_q[1];
    assign pix_eol    = fifo0_q[0];
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_leitor_framebuffer.sv
// Directed testbench for leitor_framebuffer. The RAM model returns
// addr[7:0] for every enabled read, so beat k of a frame must carry k[7:0].
module tb_leitor_framebuffer;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int N     = IMG_W * IMG_H;

    logic        clk;
    logic        reset;
    logic        start;
    logic [18:0] ram_rdaddr;
    logic        ram_rden;
    logic [7:0]  ram_data;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    leitor_framebuffer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(19), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden), .ram_data(ram_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is valid while the registered enable is high; garbage otherwise
    assign ram_data = ram_rden ? ram_rdaddr[7:0] : 8'hA5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  32'(ram_rden),   32'd0);
        chk({tag, "_addr"},  32'(ram_rdaddr), 32'd0);
        chk({tag, "_valid"}, 32'(pix_valid),  32'd0);
        chk({tag, "_data"},  32'(pix_data),   32'd0);
        chk({tag, "_sof"},   32'(pix_sof),    32'd0);
        chk({tag, "_eol"},   32'(pix_eol),    32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
    endtask

    // Consumes n_beats pixels, checking value and markers of each beat and
    // stability of the head while stalled. Optionally pulses start at
    // beats 5 and 1000, which the DUT must ignore.
    task automatic run_stream(input int n_beats, input int ready_pct,
                              input bit no_bubble, input bit pulse_start);
        int beat = 0;
        int cyc = 0;
        bit pulsed5 = 0;
        bit pulsed1000 = 0;
        logic pv_prev = 1'b0;
        logic pr_prev = 1'b0;
        logic [7:0] pd_prev = 8'h00;
        logic ps_prev = 1'b0;
        logic pe_prev = 1'b0;
        while (beat < n_beats && cyc < n_beats * 8 + 100) begin
            pix_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99, 0) < ready_pct);
            start = 1'b0;
            if (pulse_start && beat == 5 && !pulsed5) begin
                start = 1'b1;
                pulsed5 = 1;
            end
            if (pulse_start && beat == 1000 && !pulsed1000) begin
                start = 1'b1;
                pulsed1000 = 1;
            end
            if (no_bubble) chk("no_bubble", 32'(pix_valid), 32'd1);
            if (pv_prev && !pr_prev) begin
                chk("stall_valid", 32'(pix_valid), 32'd1);
                chk("stall_data",  32'(pix_data),  32'(pd_prev));
                chk("stall_sof",   32'(pix_sof),   32'(ps_prev));
                chk("stall_eol",   32'(pix_eol),   32'(pe_prev));
            end
            if (pix_valid && pix_ready) begin
                chk("beat_data", 32'(pix_data), 32'(beat[7:0]));
                chk("beat_sof",  32'(pix_sof),  32'(beat == 0));
                chk("beat_eol",  32'(pix_eol),  32'((beat % IMG_W) == IMG_W - 1));
                beat++;
            end
            pv_prev = pix_valid;
            pr_prev = pix_ready;
            pd_prev = pix_data;
            ps_prev = pix_sof;
            pe_prev = pix_eol;
            cyc++;
            step();
        end
        start = 1'b0;
        chk("stream_beats", 32'(beat), 32'(n_beats));
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_ready = 1'b0;

        // Reset held, then released with no start
        repeat (3) step();
        chk_all_zero("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_valid", 32'(pix_valid), 32'd0);
            chk("idle_rden",  32'(ram_rden),  32'd0);
        end
        chk_all_zero("idle_after_release");

        // Frame 1: full rate, start sampled at edge E
        pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("e0_rden",  32'(ram_rden),  32'd0);
        chk("e0_busy",  32'(busy),      32'd1);
        chk("e0_valid", 32'(pix_valid), 32'd0);
        step();
        chk("e1_rden",  32'(ram_rden),   32'd1);
        chk("e1_addr",  32'(ram_rdaddr), 32'd0);
        chk("e1_valid", 32'(pix_valid),  32'd0);
        step();
        chk("e2_valid", 32'(pix_valid),  32'd1);
        chk("e2_data",  32'(pix_data),   32'd0);
        chk("e2_sof",   32'(pix_sof),    32'd1);
        chk("e2_addr",  32'(ram_rdaddr), 32'd1);
        run_stream(N, 100, 1'b1, 1'b0);

`ifdef LEITOR_FRAMEBUFFER_LOOP_EN
        // Scan-out continues without a bubble into the next frame
        run_stream(8, 100, 1'b1, 1'b0);
        chk("loop_done", 32'(done), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
`else
        chk("f1_done",  32'(done),      32'd1);
        chk("f1_busy",  32'(busy),      32'd0);
        chk("f1_valid", 32'(pix_valid), 32'd0);

        // Frame 2: random backpressure plus ignored mid-frame starts
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f2_done_clr", 32'(done), 32'd0);
        chk("f2_busy",     32'(busy), 32'd1);
        run_stream(N, 70, 1'b0, 1'b1);
        chk("f2_done", 32'(done), 32'd1);
        chk("f2_busy_end", 32'(busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("f2_no_extra_valid", 32'(pix_valid), 32'd0);
            chk("f2_no_extra_rden",  32'(ram_rden),  32'd0);
        end
`endif

        // Frame 3: reset asserted at beat 5000, then a fresh frame
        pix_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        run_stream(5000, 100, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("post_reset_valid", 32'(pix_valid), 32'd0);
            chk("post_reset_rden",  32'(ram_rden),  32'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("fresh_rden", 32'(ram_rden),   32'd1);
        chk("fresh_addr", 32'(ram_rdaddr), 32'd0);
        step();
        run_stream(300, 100, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
